// File: rtl/cmp_run_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_run_monitor                                            |
// | Description : Run-length encoder for the comparator 2-bit result code.   |
// |               Consecutive equal results (2'b11 = flag 1, 2'b00 = flag 0) |
// |               are folded into (flag, length) records, delivered through  |
// |               a single-entry valid/ready output register.                |
// |                                                                          |
// | Ports       : clk, rst        clock, asynchronous active-high reset      |
// |               in_valid/ready  result sample handshake                    |
// |               in_ret          2-bit result code (01/10 illegal)          |
// |               flush           pulse: close the open run                  |
// |               out_valid/ready record handshake                           |
// |               out_flag/len    record contents (len 1..MAX_RUN)           |
// |               err_illegal     sticky illegal-code flag                   |
// |               ones_total      (CMP_RUN_STATS_EN only) saturating count   |
// |                               of accepted 2'b11 samples                  |
// |                                                                          |
// | Macro       : CMP_RUN_STATS_EN enables the ones_total statistics port.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

module cmp_run_monitor #(
   parameter int CNT_W   = 4,
   parameter int MAX_RUN = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_ret,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_flag,
   output logic [CNT_W-1:0] out_len,
`ifdef CMP_RUN_STATS_EN
   output logic [15:0]      ones_total,
`endif
   output logic             err_illegal
);

   localparam logic [CNT_W-1:0] c_max_run = CNT_W'(MAX_RUN);
   localparam logic [CNT_W-1:0] c_len_one = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_cur_flag;
   logic [CNT_W-1:0]   r_cur_len;
   logic               r_flush_pend;
   logic               r_out_valid;
   logic               r_out_flag;
   logic [CNT_W-1:0]   r_out_len;
   logic               r_err_illegal;

   logic               w_slot_free;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_legal;
   logic               w_new_flag;
   logic               w_emit;

   assign w_slot_free = !r_out_valid || out_ready;
   // A flush (requested or pending) freezes input so the closing record is
   // exactly the run that was open when flush was seen.
   assign w_in_ready  = !flush && !r_flush_pend &&
                        ((r_state == ST_IDLE) || w_slot_free);
   assign w_accept    = in_valid && w_in_ready;
   assign w_legal     = (in_ret == 2'b11) || (in_ret == 2'b00);
   assign w_new_flag  = in_ret[0];

   // Record emission: the open run is closed by a pending flush once the
   // output slot is free, by a flag change, or by reaching MAX_RUN. Accepts
   // and a pending flush never coincide because in_ready is low while
   // flush_pend is set.
   always_comb begin
      w_emit = 1'b0;
      if (r_state == ST_RUN) begin
         if (r_flush_pend && w_slot_free) begin
            w_emit = 1'b1;
         end else if (w_accept && w_legal &&
                      ((w_new_flag != r_cur_flag) || (r_cur_len == c_max_run))) begin
            w_emit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cur_flag    <= 1'b0;
         r_cur_len     <= '0;
         r_flush_pend  <= 1'b0;
         r_err_illegal <= 1'b0;
      end else begin
         if (w_accept && !w_legal) begin
            r_err_illegal <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               // flush is ignored here: there is no open run to close.
               if (w_accept && w_legal) begin
                  r_state    <= ST_RUN;
                  r_cur_flag <= w_new_flag;
                  r_cur_len  <= c_len_one;
               end
            end
            ST_RUN: begin
               if (r_flush_pend) begin
                  if (w_slot_free) begin
                     // Return to the same register image as after reset.
                     r_state      <= ST_IDLE;
                     r_flush_pend <= 1'b0;
                     r_cur_flag   <= 1'b0;
                     r_cur_len    <= '0;
                  end
               end else if (flush) begin
                  r_flush_pend <= 1'b1;
               end else if (w_accept && w_legal) begin
                  if (w_new_flag != r_cur_flag) begin
                     r_cur_flag <= w_new_flag;
                     r_cur_len  <= c_len_one;
                  end else if (r_cur_len == c_max_run) begin
                     // Full run was emitted; this sample starts the next one.
                     r_cur_len <= c_len_one;
                  end else begin
                     r_cur_len <= r_cur_len + c_len_one;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Single-entry output register. A new record may reload it in the same
   // cycle the previous one is consumed, keeping out_valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_flag  <= 1'b0;
         r_out_len   <= '0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_flag  <= r_cur_flag;
         r_out_len   <= r_cur_len;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef CMP_RUN_STATS_EN
   logic [15:0] r_ones_total;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ones_total <= 16'h0000;
      end else if (w_accept && (in_ret == 2'b11) && (r_ones_total != 16'hFFFF)) begin
         r_ones_total <= r_ones_total + 16'h0001;
      end
   end

   assign ones_total = r_ones_total;
`endif

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_flag    = r_out_flag;
   assign out_len     = r_out_len;
   assign err_illegal = r_err_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cmp_run_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cmp_run_monitor                                         |
// | Description : Table-driven self-checking bench for cmp_run_monitor.      |
// |               Each table row is one clock cycle of stimulus with the     |
// |               expected in_ready, out_valid, err_illegal and the record   |
// |               (if any) that the cycle launches. Launched records go to a |
// |               scoreboard queue and are compared again when consumed.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

module tb_cmp_run_monitor;

   localparam int CNT_W   = 4;
   localparam int MAX_RUN = 15;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_ret;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             out_flag;
   logic [CNT_W-1:0] out_len;
   logic             err_illegal;
`ifdef CMP_RUN_STATS_EN
   logic [15:0]      ones_total;
`endif

   cmp_run_monitor #(
      .CNT_W   (CNT_W),
      .MAX_RUN (MAX_RUN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ret      (in_ret),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_flag    (out_flag),
      .out_len     (out_len),
`ifdef CMP_RUN_STATS_EN
      .ones_total  (ones_total),
`endif
      .err_illegal (err_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;    // in_valid
      logic [1:0] ret;   // in_ret
      logic       fl;    // flush
      logic       ordy;  // out_ready
      logic       rdy;   // expected in_ready this cycle
      logic       ov;    // expected out_valid after the edge
      logic       rv;    // this cycle launches a record
      logic       rf;    // record flag
      logic [3:0] rl;    // record length
      logic       err;   // expected err_illegal after the edge
   } vec_t;

   vec_t       tbl[$];
   logic [4:0] sb[$];
   int         n_tests;
   int         n_fail;
   int         exp_ones;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [1:0] ret, input logic fl,
                      input logic ordy, input logic rdy, input logic ov,
                      input logic rv, input logic rf, input logic [3:0] rl,
                      input logic err);
      vec_t v;
      v.iv = iv; v.ret = ret; v.fl = fl; v.ordy = ordy; v.rdy = rdy;
      v.ov = ov; v.rv = rv; v.rf = rf; v.rl = rl; v.err = err;
      tbl.push_back(v);
   endtask

   task automatic run_table(input string tag);
      vec_t       v;
      logic [4:0] exp_rec;
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         in_valid  = v.iv;
         in_ret    = v.ret;
         flush     = v.fl;
         out_ready = v.ordy;
         #1;
         chk($sformatf("%s[%0d] in_ready", tag, i), int'(in_ready), int'(v.rdy));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s[%0d] consumed record: got %0d with nothing expected",
                        tag, i, {out_flag, out_len});
            end else begin
               exp_rec = sb.pop_front();
               chk($sformatf("%s[%0d] consumed {flag,len}", tag, i),
                   int'({out_flag, out_len}), int'(exp_rec));
            end
         end
         if (v.rdy && v.iv && (v.ret == 2'b11) && (exp_ones != 32'hFFFF)) exp_ones++;
         if (v.rv) sb.push_back({v.rf, v.rl});
         @(posedge clk);
         #1;
         chk($sformatf("%s[%0d] out_valid", tag, i), int'(out_valid), int'(v.ov));
         if (v.rv) begin
            chk($sformatf("%s[%0d] out_flag", tag, i), int'(out_flag), int'(v.rf));
            chk($sformatf("%s[%0d] out_len", tag, i), int'(out_len), int'(v.rl));
         end
         chk($sformatf("%s[%0d] err_illegal", tag, i), int'(err_illegal), int'(v.err));
`ifdef CMP_RUN_STATS_EN
         chk($sformatf("%s[%0d] ones_total", tag, i), int'(ones_total), exp_ones);
`endif
      end
      tbl.delete();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      exp_ones  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_ret    = 2'b00;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_flag", int'(out_flag), 0);
      chk("reset out_len", int'(out_len), 0);
      chk("reset err_illegal", int'(err_illegal), 0);
      chk("reset in_ready", int'(in_ready), 1);
`ifdef CMP_RUN_STATS_EN
      chk("reset ones_total", int'(ones_total), 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // 11,11,11,00 then flush
      add(1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b00, 0, 1, 1, 1, 1, 1, 3, 0);
      add(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 2'b00, 0, 1, 0, 1, 1, 0, 1, 0);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      run_table("basic");

      // 16 x 11: full run of MAX_RUN, then flush the leftover sample
      for (int k = 0; k < 15; k++) add(1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b11, 0, 1, 1, 1, 1, 1, 4'd15, 0);
      add(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 2'b00, 0, 1, 0, 1, 1, 1, 1, 0);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      run_table("maxrun");

      // Backpressure: record held, input stalled, then released
      add(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 2'b11, 0, 0, 1, 1, 1, 0, 1, 0);
      add(1, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 2'b00, 0, 1, 1, 1, 1, 1, 1, 0);
      add(0, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0);
      add(0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 2'b00, 0, 1, 0, 1, 1, 0, 1, 0);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      run_table("stall");

      // Illegal code is dropped and sets the sticky flag
      add(1, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b01, 0, 1, 1, 0, 0, 0, 0, 1);
      add(1, 2'b00, 0, 1, 1, 0, 0, 0, 0, 1);
      add(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 1);
      add(0, 2'b00, 0, 1, 0, 1, 1, 0, 3, 1);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 1);
      run_table("illegal");

      // Flush in IDLE is a no-op; then build a pending record for the reset
      add(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 1);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 1);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 1);
      add(1, 2'b11, 0, 0, 1, 0, 0, 0, 0, 1);
      add(1, 2'b11, 0, 0, 1, 0, 0, 0, 0, 1);
      add(1, 2'b00, 0, 0, 1, 1, 1, 1, 2, 1);
      run_table("idleflush");

      // Asynchronous reset mid-run with a record pending
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", int'(out_valid), 0);
      chk("async rst err_illegal", int'(err_illegal), 0);
      chk("async rst out_len", int'(out_len), 0);
      chk("async rst in_ready", int'(in_ready), 1);
      sb.delete();
      exp_ones = 0;
      @(negedge clk);
      rst = 1'b0;

      // After reset: no stale record; open run must start fresh
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b11, 0, 1, 1, 1, 1, 0, 1, 0);
      add(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 2'b00, 0, 1, 0, 1, 1, 1, 1, 0);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
      run_table("postrst");

      // 11,00,11,10,11 with back-to-back records
      add(1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 2'b00, 0, 1, 1, 1, 1, 1, 1, 0);
      add(1, 2'b11, 0, 1, 1, 1, 1, 0, 1, 0);
      add(1, 2'b10, 0, 1, 1, 0, 0, 0, 0, 1);
      add(1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 1);
      add(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 1);
      add(0, 2'b00, 0, 1, 0, 1, 1, 1, 2, 1);
      add(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 1);
      run_table("stats");
`ifdef CMP_RUN_STATS_EN
      chk("final ones_total", int'(ones_total), 4);
`endif

      chk("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
